fb_port_arbiter: RTL
====================

Name: fb_port_arbiter

Overview:
- Shares the single-port frame buffer SRAM (8-bit colour index, 19-bit address) between three clients: VGA scanout reads, sprite/draw-engine writes, and a built-in full-frame clear sequencer.
- Scanout has absolute priority because it carries a hard pixel deadline. The clear sequencer is next. The draw engine gets the remaining slots.
- Sits between the VGA colour mapper, the draw engine, and the frame buffer memory, all on CLOCK_50.

Parameters:
- ADDR_W, 19, frame buffer address width.
- DATA_W, 8, pixel data width (palette index).
- NUM_PIX, 307200, number of pixels to clear (640x480); valid addresses are 0..NUM_PIX-1.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- Reset_N  in  1  asynchronous active-low reset.
- rd_req  in  1  scanout read request; single-cycle sample.
- rd_addr  in  ADDR_W  scanout read address.
- rd_data  out  DATA_W  read data, registered.
- rd_valid  out  1  rd_data valid; one-cycle pulse.
- wr_req  in  1  draw write request; held until wr_ack.
- wr_addr  in  ADDR_W  draw write address.
- wr_data  in  DATA_W  draw write data.
- wr_ack  out  1  combinational; high in the cycle the write is accepted.
- clear_start  in  1  pulse; starts a full-frame clear.
- clear_color  in  DATA_W  fill value, captured on clear_start.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse after the last clear write issues.
- mem_addr  out  ADDR_W  SRAM address, registered.
- mem_wdata  out  DATA_W  SRAM write data, registered.
- mem_we  out  1  SRAM write enable, registered.
- mem_rdata  in  DATA_W  SRAM read data; valid one cycle after mem_addr.

Behaviour:
- Reset values: all outputs 0; clear counter 0; clear FSM in IDLE. Reset is asynchronous and aborts any clear in progress. A clear aborted this way is not resumed and produces no clear_done.
- Per-cycle grant, fixed priority:
  1. rd_req
  2. clear write, when clear_busy
  3. wr_req
- The granted operation is registered onto mem_addr / mem_wdata / mem_we in the next cycle (N+1).
- With no grant, mem_we=0 and mem_addr holds its previous value.
- Read latency:
  - rd_req sampled at N.
  - mem_addr=rd_addr, mem_we=0 at N+1.
  - mem_rdata captured at N+2.
  - rd_data and rd_valid=1 at N+3.
  - Fixed 3 cycles. Back-to-back rd_req every cycle is supported, fully pipelined with one rd_valid per request.
- Draw write handshake:
  - wr_ack = wr_req & ~rd_req & ~clear_busy, computed combinationally.
  - The requester must hold wr_addr and wr_data stable until it sees wr_ack, and may present the next write in the cycle after.
  - While clear_busy, writes stall; wr_ack stays 0.
- Clear FSM states: IDLE, FILL, DONE.
  - IDLE -> FILL on clear_start. clear_color is latched, the counter is set to 0, and clear_busy goes high the next cycle.
  - FILL: each cycle without rd_req issues a write of the latched colour to the counter address, then increments the counter. A cycle with rd_req leaves the counter unchanged.
  - When a write to address NUM_PIX-1 is granted: FILL -> DONE.
  - DONE: clear_done=1 for one cycle, clear_busy=0, then -> IDLE.
  - clear_start while in FILL or DONE is ignored.
  - clear_start in the same cycle as rd_req is still accepted.
- Counter width is ADDR_W. It never exceeds NUM_PIX-1, so it never wraps.
- Addresses ≥ NUM_PIX on rd_addr or wr_addr are passed through unchecked. Range checking is the client's responsibility.
- mem_rdata in cycles not following a read is ignored.

Decomposition:
- Package fb_pkg holds:
  - ADDR_W, DATA_W, NUM_PIX, H_RES=640, V_RES=480.
  - Enum clr_state_t {IDLE, FILL, DONE}.
  - Enum grant_t {G_NONE, G_READ, G_CLEAR, G_DRAW}.
- One sub-module, fb_clear_seq: clear FSM plus counter. It takes a "granted" input and outputs busy, done, address and colour.
- The arbiter top holds the priority logic, the memory output registers, and the 2-stage read-valid pipeline.

Test Plan:
- Reset then single read: mem model holds 0x5A at address 0x00123; rd_req at cycle 10 -> mem_addr=0x00123 with mem_we=0 at cycle 11, rd_data=0x5A and rd_valid=1 at cycle 13, rd_valid=0 at cycle 14.
- Contention: rd_req and wr_req (addr 0x00400, data 0x3C) both high at cycle N -> wr_ack=0 at N. Drop rd_req at N+1 -> wr_ack=1 at N+1; mem_we=1, mem_addr=0x00400, mem_wdata=0x3C at N+2.
- Full clear with NUM_PIX overridden to 16, clear_color=0x07, rd_req pulsed every other cycle:
  - exactly 16 writes of 0x07 to addresses 0..15, in order;
  - clear_done pulses once;
  - wr_req held throughout is acked only after clear_busy falls.
- clear_start re-pulsed mid-FILL with clear_color=0xFF -> ignored; every write still carries 0x07 and the counter does not restart.
- Reset_N driven low asynchronously mid-FILL (between clock edges) -> clear_busy, mem_we and rd_valid go to 0 immediately; after release no clear_done appears and the FSM is IDLE.
- Continuous rd_req for 64 cycles with incrementing addresses -> 64 rd_valid pulses, each carrying the model data for its address, in order, with 3-cycle latency.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and types for the frame buffer port arbiter.
package fb_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 8;
  localparam int NUM_PIX = H_RES * V_RES;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } clr_state_t;

  typedef enum logic [1:0] {
    G_NONE,
    G_READ,
    G_CLEAR,
    G_DRAW
  } grant_t;

endpackage

// File: rtl/fb_clear_seq.sv
// Full-frame clear sequencer: walks addresses 0..NUM_PIX-1 writing a latched colour,
// advancing only in cycles where the arbiter grants it the memory port.
module fb_clear_seq #(
  parameter int ADDR_W  = fb_pkg::ADDR_W,
  parameter int DATA_W  = fb_pkg::DATA_W,
  parameter int NUM_PIX = fb_pkg::NUM_PIX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] color_in,
  input  logic              granted,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] color
);

  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  clr_state_t state;

  // The counter stops on the last address rather than incrementing past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      color <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            color <= color_in;
            addr  <= '0;
            busy  <= 1'b1;
            state <= FILL;
          end
        end
        FILL: begin
          if (granted) begin
            if (addr == LAST_ADDR) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame buffer SRAM port arbiter: scanout reads first, then the clear sequencer,
// then draw-engine writes; the granted access is registered onto the SRAM bus.
module fb_port_arbiter #(
  parameter int ADDR_W  = fb_pkg::ADDR_W,
  parameter int DATA_W  = fb_pkg::DATA_W,
  parameter int NUM_PIX = fb_pkg::NUM_PIX
) (
  input  logic              CLOCK_50,
  input  logic              Reset_N,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  import fb_pkg::*;

  grant_t            grant;
  logic              clr_granted;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_color;
  logic [1:0]        rd_pipe;

  fb_clear_seq #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_PIX (NUM_PIX)
  ) u_clear_seq (
    .clk      (CLOCK_50),
    .rst_n    (Reset_N),
    .start    (clear_start),
    .color_in (clear_color),
    .granted  (clr_granted),
    .busy     (clear_busy),
    .done     (clear_done),
    .addr     (clr_addr),
    .color    (clr_color)
  );

  always_comb begin
    grant = G_NONE;
    if (rd_req) begin
      grant = G_READ;
    end else if (clear_busy) begin
      grant = G_CLEAR;
    end else if (wr_req) begin
      grant = G_DRAW;
    end
  end

  assign wr_ack      = (grant == G_DRAW);
  assign clr_granted = (grant == G_CLEAR);

  // rd_pipe tracks a read through the address and SRAM-access cycles; the
  // returned byte is captured as the third stage together with rd_valid.
  always_ff @(posedge CLOCK_50 or negedge Reset_N) begin
    if (!Reset_N) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rd_pipe   <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_pipe  <= {rd_pipe[0], (grant == G_READ)};
      rd_valid <= rd_pipe[1];
      if (rd_pipe[1]) begin
        rd_data <= mem_rdata;
      end
      case (grant)
        G_READ: begin
          mem_addr <= rd_addr;
          mem_we   <= 1'b0;
        end
        G_CLEAR: begin
          mem_addr  <= clr_addr;
          mem_wdata <= clr_color;
          mem_we    <= 1'b1;
        end
        G_DRAW: begin
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
          mem_we    <= 1'b1;
        end
        default: begin
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
